// File: rtl/bram_wr_addr_gen.sv
// Write-address generator for the OFM BRAM: one write per accepted word, 2-D pixel/word walk.
// Optional stall counter output enabled by defining BRAM_WR_STALL_CNT_EN.
module bram_wr_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LANES  = 8,
  parameter int unsigned PIX_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       ofm_c,
  input  logic [PIX_W-1:0]  ofm_pixels,
  input  logic [PIX_W-1:0]  pixel_stride,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic              last_out,
  output logic              busy,
  output logic              done,
  output logic              err_cfg
`ifdef BRAM_WR_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned LaneShift = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [16:0]       wpp_q, wpp_d;
  logic [16:0]       word_cnt_q, word_cnt_d;
  logic [PIX_W-1:0]  pixels_q, pixels_d;
  logic [PIX_W-1:0]  stride_q, stride_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] pix_base_q, pix_base_d;
  logic [ADDR_W-1:0] write_addr_d;
  logic              write_en_d, last_d, done_d, err_d;
  logic              accept, cfg_bad, start_ok, last_word, last_pixel;
  logic [16:0]       wpp_new;

  // Partial words round up: ceil(ofm_c / LANES).
  assign wpp_new    = (17'(ofm_c) + 17'(LANES - 1)) >> LaneShift;
  assign cfg_bad    = (ofm_c == 16'd0) || (ofm_pixels == '0);
  assign start_ok   = (state_q == StIdle) && start && !abort && !cfg_bad;
  assign ready_out  = (state_q == StRun);
  assign busy       = (state_q == StRun);
  assign accept     = valid_in && ready_out;
  assign last_word  = (word_cnt_q == wpp_q - 17'd1);
  assign last_pixel = (pix_cnt_q == pixels_q - PIX_W'(1));

  always_comb begin
    state_d      = state_q;
    wpp_d        = wpp_q;
    word_cnt_d   = word_cnt_q;
    pixels_d     = pixels_q;
    stride_d     = stride_q;
    pix_cnt_d    = pix_cnt_q;
    pix_base_d   = pix_base_q;
    write_addr_d = write_addr;
    write_en_d   = 1'b0;
    last_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    if (abort) begin
      state_d    = StIdle;
      word_cnt_d = '0;
      pix_cnt_d  = '0;
      pix_base_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              wpp_d      = wpp_new;
              pixels_d   = ofm_pixels;
              stride_d   = pixel_stride;
              pix_base_d = base_addr;
              word_cnt_d = '0;
              pix_cnt_d  = '0;
              state_d    = StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            write_en_d   = 1'b1;
            write_addr_d = pix_base_q + ADDR_W'(word_cnt_q);
            if (last_word) begin
              word_cnt_d = '0;
              pix_cnt_d  = pix_cnt_q + PIX_W'(1);
              pix_base_d = pix_base_q + ADDR_W'(stride_q);
              if (last_pixel) begin
                last_d  = 1'b1;
                state_d = StDone;
              end
            end else begin
              word_cnt_d = word_cnt_q + 17'd1;
            end
          end
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wpp_q      <= '0;
      word_cnt_q <= '0;
      pixels_q   <= '0;
      stride_q   <= '0;
      pix_cnt_q  <= '0;
      pix_base_q <= '0;
      write_addr <= '0;
      write_en   <= 1'b0;
      last_out   <= 1'b0;
      done       <= 1'b0;
      err_cfg    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wpp_q      <= wpp_d;
      word_cnt_q <= word_cnt_d;
      pixels_q   <= pixels_d;
      stride_q   <= stride_d;
      pix_cnt_q  <= pix_cnt_d;
      pix_base_q <= pix_base_d;
      write_addr <= write_addr_d;
      write_en   <= write_en_d;
      last_out   <= last_d;
      done       <= done_d;
      err_cfg    <= err_d;
    end
  end

`ifdef BRAM_WR_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of RUN cycles with no upstream word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && !valid_in && !abort && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_bram_wr_addr_gen.sv
// Bench for bram_wr_addr_gen: directed layers plus random layers against a queue-based
// model that precomputes every layer's address list at start.
module tb_bram_wr_addr_gen;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] ofm_c = '0;
  logic [23:0] ofm_pixels = '0;
  logic [23:0] pixel_stride = '0;

  logic        ready_out, write_en, last_out, busy, done, err_cfg;
  logic [31:0] write_addr;
  logic        ready8, we8, last8, busy8, done8, err8;
  logic [7:0]  addr8;
`ifdef BRAM_WR_STALL_CNT_EN
  logic [31:0] stall_cnt, stall8;
`endif

  always #5 clk = ~clk;

  bram_wr_addr_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr),
    .ofm_c(ofm_c), .ofm_pixels(ofm_pixels), .pixel_stride(pixel_stride),
    .valid_in(valid_in), .ready_out(ready_out), .write_en(write_en),
    .write_addr(write_addr), .last_out(last_out), .busy(busy), .done(done),
    .err_cfg(err_cfg)
`ifdef BRAM_WR_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  bram_wr_addr_gen #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr[7:0]),
    .ofm_c(ofm_c), .ofm_pixels(ofm_pixels), .pixel_stride(pixel_stride),
    .valid_in(valid_in), .ready_out(ready8), .write_en(we8),
    .write_addr(addr8), .last_out(last8), .busy(busy8), .done(done8),
    .err_cfg(err8)
`ifdef BRAM_WR_STALL_CNT_EN
    , .stall_cnt(stall8)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 run, 2 done; q holds the addresses still to be written.
  int          m_state = 0;
  logic [31:0] q[$];
  logic [31:0] e_addr = '0;
  bit          e_we = 0, e_last = 0, e_done = 0, e_err = 0;
  longint      e_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    q.delete();
    e_addr = '0;
    e_we = 0; e_last = 0; e_done = 0; e_err = 0;
    e_stall = 0;
  endtask

  task automatic model_edge();
    bit n_we = 0, n_last = 0, n_done = 0, n_err = 0;
    if (abort) begin
      m_state = 0;
      q.delete();
    end else begin
      case (m_state)
        0: if (start) begin
          if (ofm_c == 0 || ofm_pixels == 0) begin
            n_err = 1;
          end else begin
            int wpp = (int'(ofm_c) + 7) / 8;
            q.delete();
            for (int p = 0; p < int'(ofm_pixels); p++)
              for (int w = 0; w < wpp; w++)
                q.push_back(base_addr + 32'(p) * 32'(pixel_stride) + 32'(w));
            e_stall = 0;
            m_state = 1;
          end
        end
        1: begin
          if (!valid_in) begin
            e_stall++;
          end else begin
            n_we = 1;
            e_addr = q.pop_front();
            if (q.size() == 0) begin
              n_last = 1;
              m_state = 2;
            end
          end
        end
        default: begin
          n_done = 1;
          m_state = 0;
        end
      endcase
    end
    e_we = n_we; e_last = n_last; e_done = n_done; e_err = n_err;
  endtask

  task automatic check_all();
    logic [31:0] run_exp;
    run_exp = (m_state == 1) ? 32'd1 : 32'd0;
    chk("write_en", 32'(write_en), 32'(e_we));
    chk("write_addr", write_addr, e_addr);
    chk("last_out", 32'(last_out), 32'(e_last));
    chk("done", 32'(done), 32'(e_done));
    chk("err_cfg", 32'(err_cfg), 32'(e_err));
    chk("busy", 32'(busy), run_exp);
    chk("ready_out", 32'(ready_out), run_exp);
    chk("w8_write_en", 32'(we8), 32'(e_we));
    chk("w8_write_addr", 32'(addr8), e_addr & 32'hFF);
    chk("w8_last_out", 32'(last8), 32'(e_last));
    chk("w8_done", 32'(done8), 32'(e_done));
`ifdef BRAM_WR_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, e_stall[31:0]);
`endif
  endtask

  task automatic step(input bit v, input bit s, input bit a);
    valid_in = v;
    start = s;
    abort = a;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_cfg(input logic [31:0] b, input int c, input int p, input int st);
    base_addr = b;
    ofm_c = 16'(c);
    ofm_pixels = 24'(p);
    pixel_stride = 24'(st);
  endtask

  initial begin
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Contiguous layer: 0x100..0x105
    set_cfg(32'h100, 16, 3, 2);
    step(0, 1, 0);
    repeat (9) step(1, 0, 0);

    // Round-up to 3 words per pixel with padded stride
    set_cfg(32'h0, 20, 2, 4);
    step(0, 1, 0);
    repeat (6) step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // Bubbles
    set_cfg(32'h0, 8, 4, 1);
    step(0, 1, 0);
    foreach (pat[i]) step(pat[i], 0, 0);
    repeat (3) step(0, 0, 0);
`ifdef BRAM_WR_STALL_CNT_EN
    chk("stall_bubbles", stall_cnt, 32'd3);
`endif

    // Bad configs
    set_cfg(32'h10, 0, 4, 1);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    set_cfg(32'h10, 8, 0, 1);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);

    // Abort after two accepts, abort+start together, then restart and reset mid-run
    set_cfg(32'h0, 8, 8, 1);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    step(1, 0, 1);
    repeat (3) step(1, 0, 0);
    step(0, 1, 1);
    repeat (2) step(1, 0, 0);
    set_cfg(32'h40, 8, 8, 1);
    step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Address wrap on the 8-bit instance: FE, FF, 00, 01
    set_cfg(32'hFE, 8, 4, 1);
    step(0, 1, 0);
    repeat (4) step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    // Random layers with config churn, stray starts and rare aborts
    for (int layer = 0; layer < 40; layer++) begin
      int cyc = 0;
      set_cfg($urandom, $urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 8));
      step(0, 1, 0);
      while (m_state != 0 && cyc < 400) begin
        set_cfg($urandom, $urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 8));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        cyc++;
      end
      repeat (2) step(0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
